bu2_nwc_pipe: RTL and testbench

- Parametrised, valid-tracked radix-2 butterfly for the NWC NTT/INTT datapath.
- Supports two modes:
  - Cooley-Tukey forward (CT): a + w·b, a − w·b.
  - Gentleman-Sande inverse (GS): a + b, (a − b)·w.
- GS has an optional ×2⁻¹ mod q output scaling for in-place INTT normalisation.
- Fixed latency in both modes, with a global stall.
- Twiddle and modulus are forwarded, aligned with the data, for chaining into the next stage.

---
 rtl/bu2_nwc_pipe.sv | 167 ++++++++++++++++
 tb/tb_bu2_nwc_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bu2_nwc_pipe.sv
// Radix-2 NWC butterfly: CT (forward) and GS (inverse, optional x2^-1).
// Fixed LAT = MUL_LAT+2 cycles; en=0 freezes every stage.
// Twiddle and modulus travel with the data for chaining into the next stage.
module bu2_nwc_pipe #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              half_en,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] twiddle,
  input  logic [DATA_W-1:0] modulus,
  output logic              out_valid,
  output logic [DATA_W-1:0] BU_a,
  output logic [DATA_W-1:0] BU_b,
  output logic [DATA_W-1:0] twiddle_BU_out,
  output logic [DATA_W-1:0] modulus_BU_out,
  output logic              busy
);
  localparam int LAT = MUL_LAT + 2;

  function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a, b, q);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] f_sub(input logic [DATA_W-1:0] a, b, q);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, q};
    return d[DATA_W-1:0];
  endfunction

  // x/2 mod q for odd q: odd x is made even by adding q (needs one extra bit)
  function automatic logic [DATA_W-1:0] f_half(input logic [DATA_W-1:0] x, q);
    logic [DATA_W:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return t[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] f_red(input logic [2*DATA_W-1:0] p,
                                              input logic [DATA_W-1:0]   q);
    logic [2*DATA_W-1:0] r;
    r = p % {{DATA_W{1'b0}}, q};
    return r[DATA_W-1:0];
  endfunction

  logic                r_vld [LAT];
  logic [DATA_W-1:0]   r_tw  [LAT];
  logic [DATA_W-1:0]   r_q   [LAT];
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_xd  [MUL_LAT];
  logic [DATA_W-1:0]   r_m   [MUL_LAT];
  logic [DATA_W-1:0]   r_bu_a;
  logic [DATA_W-1:0]   r_bu_b;
  logic                r_mode;
  logic                r_half;

  logic                w_busy;
  logic                w_cap;
  logic                w_mode;
  logic [DATA_W-1:0]   w_x;
  logic [DATA_W-1:0]   w_y;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_fin_a;
  logic [DATA_W-1:0]   w_fin_b;

  // busy: any accepted beat still somewhere in the valid shift register
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < LAT; i++) w_busy = w_busy | r_vld[i];
  end

  // The capturing beat already uses the new mode; later stages read the latch,
  // which cannot change again until the pipe has drained.
  assign w_cap  = en & in_valid & ~w_busy;
  assign w_mode = w_cap ? mode : r_mode;

  // Stage 1 front end: CT passes a,b through; GS forms a+b and a-b
  always_comb begin
    w_x = in1;
    w_y = in2;
    if (w_mode) begin
      w_x = f_add(in1, in2, modulus);
      w_y = f_sub(in1, in2, modulus);
    end
  end

  assign w_prod = {{DATA_W{1'b0}}, r_y} * {{DATA_W{1'b0}}, r_tw[0]};

  // Last stage: CT add/sub around the product, GS pass-through with optional halving
  always_comb begin
    w_fin_a = '0;
    w_fin_b = '0;
    if (!r_mode) begin
      w_fin_a = f_add(r_xd[MUL_LAT-1], r_m[MUL_LAT-1], r_q[LAT-2]);
      w_fin_b = f_sub(r_xd[MUL_LAT-1], r_m[MUL_LAT-1], r_q[LAT-2]);
    end else if (r_half) begin
      w_fin_a = f_half(r_xd[MUL_LAT-1], r_q[LAT-2]);
      w_fin_b = f_half(r_m[MUL_LAT-1], r_q[LAT-2]);
    end else begin
      w_fin_a = r_xd[MUL_LAT-1];
      w_fin_b = r_m[MUL_LAT-1];
    end
  end

  // Pipeline registers: all stages shift together on en, data loads even when invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_tw[i]  <= '0;
        r_q[i]   <= '0;
      end
      for (int i = 0; i < MUL_LAT; i++) begin
        r_xd[i] <= '0;
        r_m[i]  <= '0;
      end
      r_x    <= '0;
      r_y    <= '0;
      r_bu_a <= '0;
      r_bu_b <= '0;
      r_mode <= 1'b0;
      r_half <= 1'b0;
    end else if (en) begin
      if (w_cap) begin
        r_mode <= mode;
        r_half <= half_en;
      end
      r_vld[0] <= in_valid;
      r_tw[0]  <= twiddle;
      r_q[0]   <= modulus;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tw[i]  <= r_tw[i-1];
        r_q[i]   <= r_q[i-1];
      end
      r_x <= w_x;
      r_y <= w_y;
      // product is reduced as it is registered; the trailing stages give retiming room
      r_m[0]  <= f_red(w_prod, r_q[0]);
      r_xd[0] <= r_x;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_m[i]  <= r_m[i-1];
        r_xd[i] <= r_xd[i-1];
      end
      r_bu_a <= w_fin_a;
      r_bu_b <= w_fin_b;
    end
  end

  assign out_valid      = r_vld[LAT-1];
  assign BU_a           = r_bu_a;
  assign BU_b           = r_bu_b;
  assign twiddle_BU_out = r_tw[LAT-1];
  assign modulus_BU_out = r_q[LAT-1];
  assign busy           = w_busy;

endmodule

// File: tb/tb_bu2_nwc_pipe.sv
// Bench for bu2_nwc_pipe: directed table, hand sequences and random traffic,
// all checked cycle by cycle against a beat-level scoreboard model.
module tb_bu2_nwc_pipe;
  localparam int W   = 32;
  localparam int ML  = 3;
  localparam int LAT = ML + 2;

  logic         clk = 1'b0;
  logic         rst, en, in_valid, mode, half_en;
  logic [W-1:0] in1, in2, twiddle, modulus;
  logic         out_valid, busy;
  logic [W-1:0] BU_a, BU_b, twiddle_BU_out, modulus_BU_out;

  always #5 clk = ~clk;

  bu2_nwc_pipe #(.DATA_W(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
    .half_en(half_en), .in1(in1), .in2(in2), .twiddle(twiddle),
    .modulus(modulus), .out_valid(out_valid), .BU_a(BU_a), .BU_b(BU_b),
    .twiddle_BU_out(twiddle_BU_out), .modulus_BU_out(modulus_BU_out),
    .busy(busy)
  );

  typedef struct {
    logic m; logic h;
    longint unsigned a, b, w, q, ea, eb;
  } vec_t;

  typedef struct {
    int c;
    longint unsigned ea, eb, w, q;
  } beat_t;

  beat_t sb[$];
  int    en_cnt = 0;
  logic  m_mode = 1'b0, m_half = 1'b0;
  int    n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  function automatic longint unsigned halve(input longint unsigned x, input longint unsigned q);
    return (x % 2 == 0) ? x / 2 : (x + q) / 2;
  endfunction

  task automatic ref_bu(input logic m, input logic h,
                        input longint unsigned a, b, w, q,
                        output longint unsigned ea, eb);
    longint unsigned p;
    if (!m) begin
      p  = (b * w) % q;
      ea = (a + p) % q;
      eb = (a + q - p) % q;
    end else begin
      ea = (a + b) % q;
      eb = (((a + q - b) % q) * w) % q;
      if (h) begin
        ea = halve(ea, q);
        eb = halve(eb, q);
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it
  task automatic cyc(input logic e, input logic v, input logic m, input logic h,
                     input longint unsigned a, b, w, q);
    logic  busy_m, exp_v;
    beat_t bt;
    en = e; in_valid = v; mode = m; half_en = h;
    in1 = a[W-1:0]; in2 = b[W-1:0]; twiddle = w[W-1:0]; modulus = q[W-1:0];
    busy_m = (sb.size() != 0);
    @(posedge clk);
    if (e) begin
      if (v) begin
        if (!busy_m) begin
          m_mode = m;
          m_half = h;
        end
        ref_bu(m_mode, m_half, a, b, w, q, bt.ea, bt.eb);
        bt.c = en_cnt + 1;
        bt.w = w;
        bt.q = q;
        sb.push_back(bt);
      end
      en_cnt++;
      while (sb.size() != 0 && sb[0].c + LAT - 1 < en_cnt) void'(sb.pop_front());
    end
    #1;
    exp_v = (sb.size() != 0) && (sb[0].c + LAT - 1 == en_cnt);
    chk("out_valid", out_valid, exp_v);
    chk("busy", busy, sb.size() != 0);
    if (exp_v && out_valid) begin
      chk("BU_a", BU_a, sb[0].ea);
      chk("BU_b", BU_b, sb[0].eb);
      chk("twiddle_out", twiddle_BU_out, sb[0].w);
      chk("modulus_out", modulus_BU_out, sb[0].q);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 17);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_BU_a"}, BU_a, 0);
    chk({tag, "_BU_b"}, BU_b, 0);
    chk({tag, "_twiddle_out"}, twiddle_BU_out, 0);
    chk({tag, "_modulus_out"}, modulus_BU_out, 0);
  endtask

  localparam longint unsigned QB = 64'd4294967291;

  vec_t vt[9];
  int   hits;
  longint unsigned q, a, b, w;

  initial begin
    vt[0] = '{m:1'b0, h:1'b0, a:5,      b:7,      w:3,      q:17, ea:9,  eb:1};
    vt[1] = '{m:1'b1, h:1'b0, a:5,      b:7,      w:3,      q:17, ea:12, eb:11};
    vt[2] = '{m:1'b1, h:1'b1, a:5,      b:7,      w:3,      q:17, ea:6,  eb:14};
    vt[3] = '{m:1'b0, h:1'b0, a:16,     b:16,     w:16,     q:17, ea:0,  eb:15};
    vt[4] = '{m:1'b0, h:1'b1, a:50,     b:60,     w:70,     q:97, ea:79, eb:21};
    vt[5] = '{m:1'b1, h:1'b0, a:50,     b:60,     w:70,     q:97, ea:13, eb:76};
    vt[6] = '{m:1'b1, h:1'b1, a:50,     b:60,     w:70,     q:97, ea:55, eb:38};
    vt[7] = '{m:1'b0, h:1'b0, a:QB-1,   b:QB-1,   w:QB-1,   q:QB, ea:0,  eb:QB-2};
    vt[8] = '{m:1'b1, h:1'b1, a:QB-1,   b:QB-1,   w:2,      q:QB, ea:QB-1, eb:0};

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 1'b0; half_en = 1'b0;
    in1 = '0; in2 = '0; twiddle = '0; modulus = 32'd17;
    #12;
    reset_outputs_zero("por");
    rst = 1'b0;

    // directed vectors, one isolated beat each; result must appear exactly LAT cycles later
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b1, vt[i].m, vt[i].h, vt[i].a, vt[i].b, vt[i].w, vt[i].q);
      hits = 0;
      for (int k = 1; k <= LAT + 1; k++) begin
        if (k < LAT) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 17);
        else         cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 17);
        if (out_valid) begin
          hits++;
          chk($sformatf("vec%0d_latency", i), k, LAT - 1);
          chk($sformatf("vec%0d_BU_a", i), BU_a, vt[i].ea);
          chk($sformatf("vec%0d_BU_b", i), BU_b, vt[i].eb);
        end
      end
      chk($sformatf("vec%0d_valid_count", i), hits, 1);
      chk($sformatf("vec%0d_drained", i), busy, 0);
    end

    // back-to-back boundary beats: two consecutive results
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16, 16, 16, 17);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 16, 17);
    idle(LAT + 1);

    // stall mid-flight, then again while a result sits on the output
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 11, 22, 33, 97);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 44, 55, 66, 97);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 77, 88, 96, 97);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1, 2, 3, 17);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3, 2, 1, 17);
    idle(LAT + 1);

    // mode latch: GS request while busy is ignored; honoured once drained
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5, 7, 3, 17);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5, 7, 3, 17);
    idle(LAT + 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5, 7, 3, 17);
    idle(LAT + 1);

    // random traffic: mixed moduli, stalls, bubbles and mode requests
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) q = longint'($urandom_range(3, 255)) | 1;
      else begin
        q = longint'($urandom) | 1;
        if (q < 3) q = 3;
      end
      a = longint'($urandom) % q;
      b = longint'($urandom) % q;
      w = longint'($urandom) % q;
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, w, q);
    end
    idle(LAT + 1);

    // async reset with three beats in flight
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5, 7, 3, 17);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 6, 8, 4, 17);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 9, 10, 12, 17);
    #2 rst = 1'b1;
    #1;
    reset_outputs_zero("async_rst");
    sb.delete();
    m_mode = 1'b0;
    m_half = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
